// File: rtl/plant_sensor_model_pkg.sv
// Shared constants for the plant emulator: motor command codes and
// the encoding of the start-button debounce state machine.
package plant_sensor_model_pkg;

    localparam logic [1:0] MOTOR_STOP    = 2'b00;
    localparam logic [1:0] MOTOR_MIX     = 2'b01;
    localparam logic [1:0] MOTOR_DRAIN   = 2'b10;
    localparam logic [1:0] MOTOR_ILLEGAL = 2'b11;

    localparam logic [1:0] DEB_LO      = 2'd0;
    localparam logic [1:0] DEB_WAIT_HI = 2'd1;
    localparam logic [1:0] DEB_HI      = 2'd2;
    localparam logic [1:0] DEB_WAIT_LO = 2'd3;

endpackage

// File: rtl/plant_sensor_model_debounce_pulse.sv
// Start-button conditioning: two-flop synchroniser, debounce FSM, press pulse.
// Ports: clk, rst (sync, active-high), raw (async button), pulse (1 cycle on accepted press).
module debounce_pulse
    import plant_sensor_model_pkg::*;
#(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // The WAIT states need DEB_CYC consecutive agreeing samples; the
    // count starts at 0 on entry, so the move happens on sample DEB_CYC.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= DEB_LO;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            case (state)
                DEB_LO: begin
                    if (sync2) begin
                        state <= DEB_WAIT_HI;
                        cnt   <= '0;
                    end
                end
                DEB_WAIT_HI: begin
                    if (!sync2) begin
                        state <= DEB_LO;
                    end else if (cnt == LAST) begin
                        state <= DEB_HI;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DEB_HI: begin
                    if (!sync2) begin
                        state <= DEB_WAIT_LO;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (sync2) begin
                        state <= DEB_HI;
                    end else if (cnt == LAST) begin
                        state <= DEB_LO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/plant_sensor_model.sv
// Closed-loop plant emulator: tank level (fill/drain) and heater temperature.
// Ports: clk, rst, M/G/C actuator commands, btn_raw/item_raw async inputs;
// S2/S1/S0 sensors, P start pulse, level/temp model state, sticky fault.
module plant_sensor_model
    import plant_sensor_model_pkg::*;
#(
    parameter int LEVEL_MAX      = 200,
    parameter int LEVEL_FULL     = 150,
    parameter int LEVEL_MIN_HEAT = 20,
    parameter int FILL_STEP      = 2,
    parameter int DRAIN_STEP     = 3,
    parameter int TEMP_AMB       = 25,
    parameter int TEMP_MAX       = 99,
    parameter int TEMP_SET       = 60,
    parameter int HEAT_DIV       = 16,
    parameter int COOL_DIV       = 64,
    parameter int DEB_CYC        = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] M,
    input  logic       G,
    input  logic       C,
    input  logic       btn_raw,
    input  logic       item_raw,
    output logic       S2,
    output logic       S1,
    output logic       S0,
    output logic       P,
    output logic [7:0] level,
    output logic [7:0] temp,
    output logic       fault
);

    logic        fill_only;
    logic        drain_only;
    logic        fault_set;
    logic        heat_en;
    logic        heat_q;
    logic        step;
    logic        item_s1;
    logic [8:0]  level_up;
    logic [8:0]  level_dn;
    logic [7:0]  level_next;
    logic [7:0]  temp_next;
    logic [15:0] div_cnt;
    logic [15:0] div_base;
    logic [15:0] div_last;

    always_comb begin
        // Valve open while draining cancels out: level holds.
        fill_only  = G && (M != MOTOR_DRAIN);
        drain_only = !G && (M == MOTOR_DRAIN);
        level_up   = {1'b0, level} + 9'(FILL_STEP);
        level_dn   = {1'b0, level} - 9'(DRAIN_STEP);
        level_next = level;
        if (fill_only) begin
            level_next = (level_up > 9'(LEVEL_MAX)) ? 8'(LEVEL_MAX) : level_up[7:0];
        end else if (drain_only) begin
            // Bit 8 is the borrow: the drain went below empty.
            level_next = level_dn[8] ? 8'd0 : level_dn[7:0];
        end

        // The heater is already off in the cycle the fault is detected.
        fault_set = (M == MOTOR_ILLEGAL) ||
                    (C && (level < 8'(LEVEL_MIN_HEAT)));
        heat_en   = C && !fault && !fault_set;

        // A heat/cool mode change restarts the divider from zero.
        div_base = (heat_en != heat_q) ? 16'd0 : div_cnt;
        div_last = heat_en ? 16'(HEAT_DIV - 1) : 16'(COOL_DIV - 1);
        step     = (div_base == div_last);

        temp_next = temp;
        if (step) begin
            if (heat_en) begin
                if (temp < 8'(TEMP_MAX)) begin
                    temp_next = temp + 8'd1;
                end
            end else begin
                if (temp > 8'(TEMP_AMB)) begin
                    temp_next = temp - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= 8'd0;
            temp    <= 8'(TEMP_AMB);
            div_cnt <= 16'd0;
            heat_q  <= 1'b0;
            fault   <= 1'b0;
            S1      <= 1'b0;
            S0      <= 1'b0;
            item_s1 <= 1'b0;
            S2      <= 1'b0;
        end else begin
            level   <= level_next;
            temp    <= temp_next;
            div_cnt <= step ? 16'd0 : div_base + 16'd1;
            heat_q  <= heat_en;
            fault   <= fault | fault_set;
            S1      <= (level >= 8'(LEVEL_FULL));
            S0      <= (temp >= 8'(TEMP_SET));
            item_s1 <= item_raw;
            S2      <= item_s1;
        end
    end

    debounce_pulse #(
        .DEB_CYC(DEB_CYC)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw),
        .pulse(P)
    );

endmodule

// File: tb/tb_plant_sensor_model.sv
// Directed bench for plant_sensor_model with a scoreboard of expected values.
// Expectations are queued when stimulus is applied and popped at observation.
module tb_plant_sensor_model;

    localparam int DEB = 8;
    // 2 synchroniser edges + DEB stable samples + registered pulse.
    localparam int P_LAT = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] M;
    logic       G;
    logic       C;
    logic       btn_raw;
    logic       item_raw;
    logic       S2;
    logic       S1;
    logic       S0;
    logic       P;
    logic [7:0] level;
    logic [7:0] temp;
    logic       fault;

    int n_assert = 0;
    int n_fail   = 0;
    int p_count  = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    plant_sensor_model #(
        .FILL_STEP (1),
        .DRAIN_STEP(1),
        .LEVEL_FULL(10),
        .HEAT_DIV  (4),
        .TEMP_SET  (28),
        .DEB_CYC   (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .M       (M),
        .G       (G),
        .C       (C),
        .btn_raw (btn_raw),
        .item_raw(item_raw),
        .S2      (S2),
        .S1      (S1),
        .S0      (S0),
        .P       (P),
        .level   (level),
        .temp    (temp),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (P === 1'b1) p_count++;
    end

    task automatic sb_push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0d expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits up to 40 cycles after a press; returns cycles to first P (0 if none).
    task automatic press_latency(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (P === 1'b1 && lat == 0) lat = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;

        rst = 1'b1; M = 2'b00; G = 1'b0; C = 1'b0;
        btn_raw = 1'b0; item_raw = 1'b0;
        cyc(3);
        rst = 1'b0;

        sb_push("rst_level", 0);
        sb_push("rst_temp", 25);
        sb_push("rst_flags", 0);
        sb_check(level);
        sb_check(temp);
        sb_check({11'd0, S2, S1, S0, P, fault});

        item_raw = 1'b1;
        sb_push("s2_lag1", 0);
        sb_push("s2_lag2", 1);
        cyc(1); sb_check(S2);
        cyc(1); sb_check(S2);
        item_raw = 1'b0;

        G = 1'b1;
        sb_push("fill_level", 10);
        sb_push("fill_s1_lag", 0);
        sb_push("fill_s1", 1);
        cyc(10); sb_check(level); sb_check(S1);
        G = 1'b0;
        cyc(1); sb_check(S1);

        M = 2'b10;
        sb_push("drain_level", 6);
        sb_push("drain_s1", 0);
        cyc(4); sb_check(level); sb_check(S1);

        G = 1'b1;
        sb_push("fill_drain_hold", 6);
        cyc(3); sb_check(level);

        M = 2'b00;
        sb_push("refill_level", 30);
        cyc(24); sb_check(level);
        G = 1'b0;

        C = 1'b1;
        sb_push("heat_temp", 28);
        sb_push("heat_s0_lag", 0);
        sb_push("heat_s0", 1);
        sb_push("cool_first", 28);
        cyc(12); sb_check(temp); sb_check(S0);
        C = 1'b0;
        cyc(1); sb_check(S0); sb_check(temp);

        sb_push("cool_63", 28);
        sb_push("cool_64", 27);
        sb_push("cool_floor", 25);
        sb_push("cool_s0_off", 0);
        cyc(62); sb_check(temp);
        cyc(1);  sb_check(temp);
        cyc(256); sb_check(temp); sb_check(S0);

        base = p_count;
        for (int r = 0; r < 3; r++) begin
            btn_raw = 1'b1; cyc(3);
            btn_raw = 1'b0; cyc(3);
        end
        btn_raw = 1'b1;
        sb_push("btn_latency", 16'(P_LAT));
        sb_push("btn_pulses", 1);
        press_latency(lat);
        sb_check(16'(lat));
        sb_check(16'(p_count - base));

        base = p_count;
        btn_raw = 1'b0;
        sb_push("release_pulses", 0);
        cyc(30);
        sb_check(16'(p_count - base));

        M = 2'b11;
        sb_push("fault_illegal", 1);
        cyc(1); sb_check(fault);
        M = 2'b00;
        C = 1'b1;
        G = 1'b1;
        sb_push("fault_level_runs", 33);
        sb_push("fault_no_heat", 25);
        sb_push("fault_sticky", 1);
        cyc(3); sb_check(level);
        G = 1'b0;
        cyc(17); sb_check(temp); sb_check(fault);
        C = 1'b0;

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        G = 1'b1;
        sb_push("rst_fault_clear", 0);
        sb_push("dry_level", 5);
        sb_check(fault);
        cyc(5); sb_check(level);
        G = 1'b0;
        C = 1'b1;
        sb_push("fault_dry", 1);
        sb_push("dry_no_heat", 25);
        cyc(1); sb_check(fault);
        cyc(8); sb_check(temp);
        C = 1'b0;

        btn_raw = 1'b1;
        G = 1'b1;
        cyc(6);
        rst = 1'b1;
        sb_push("rst_mid_level", 0);
        sb_push("rst_mid_fault", 0);
        cyc(1); sb_check(level); sb_check(fault);
        rst = 1'b0;
        G = 1'b0;
        base = p_count;
        sb_push("held_btn_latency", 16'(P_LAT));
        sb_push("held_btn_pulses", 1);
        press_latency(lat);
        sb_check(16'(lat));
        sb_check(16'(p_count - base));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
